// File: rtl/pulse_pkg.sv
// Shared definitions for the edge/pulse conditioning blocks: FSM state encoding,
// initial-level encodings and a helper that maps a reset level to its stable state.
package pulse_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } pulse_state_e;

    localparam logic INIT_LO = 1'b0;
    localparam logic INIT_HI = 1'b1;

    function automatic pulse_state_e init_state(input logic init_level);
        if (init_level == INIT_HI) begin
            init_state = STABLE_HI;
        end else begin
            init_state = STABLE_LO;
        end
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to INIT.
module sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{INIT}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/edge_pulse_gen.sv
// Synchronize, debounce and edge-detect a raw asynchronous level.
// Optional feature macro: EDGE_CNT_EN adds a saturating accepted-edge counter.
module edge_pulse_gen
    import pulse_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 8,
    parameter int   CNT_W       = 8,
    parameter logic INIT_LEVEL  = 1'b0,
    parameter int   ECNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_in,
    output logic              level,
    output logic              rise_p,
    output logic              fall_p
`ifdef EDGE_CNT_EN
    ,
    input  logic              edge_cnt_clr,
    output logic [ECNT_W-1:0] edge_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_pulse_gen: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 2) begin : g_bad_filter
        $error("edge_pulse_gen: FILTER_LEN must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(FILTER_LEN)) begin : g_bad_cnt_w
        $error("edge_pulse_gen: CNT_W too narrow for FILTER_LEN");
    end
    if (ECNT_W < 1) begin : g_bad_ecnt_w
        $error("edge_pulse_gen: ECNT_W must be at least 1");
    end

    logic             ds_s;
    pulse_state_e     state_r;
    pulse_state_e     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic             rise_r;
    logic             rise_nxt_s;
    logic             fall_r;
    logic             fall_nxt_s;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (INIT_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_in),
        .q     (ds_s)
    );

    // Debounce FSM: a new value must be seen FILTER_LEN samples in a row to be accepted.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            STABLE_LO: begin
                if (ds_s) begin
                    state_nxt_s = CHK_HI;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            CHK_HI: begin
                if (!ds_s) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!ds_s) begin
                    state_nxt_s = CHK_LO;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            CHK_LO: begin
                if (ds_s) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b0;
                    fall_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = init_state(level_r);
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= init_state(INIT_LEVEL);
            cnt_r   <= CNT_ZERO;
            level_r <= INIT_LEVEL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    assign level  = level_r;
    assign rise_p = rise_r;
    assign fall_p = fall_r;

`ifdef EDGE_CNT_EN
    localparam logic [ECNT_W-1:0] ECNT_ZERO = {ECNT_W{1'b0}};
    localparam logic [ECNT_W-1:0] ECNT_ONE  = ECNT_W'(1);
    localparam logic [ECNT_W-1:0] ECNT_MAX  = {ECNT_W{1'b1}};

    logic [ECNT_W-1:0] edge_cnt_r;

    // Count accepted edges in the same cycle their pulse is registered; a clear
    // coinciding with an edge still records that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= ECNT_ZERO;
        end else if (edge_cnt_clr && (rise_nxt_s || fall_nxt_s)) begin
            edge_cnt_r <= ECNT_ONE;
        end else if (edge_cnt_clr) begin
            edge_cnt_r <= ECNT_ZERO;
        end else if ((rise_nxt_s || fall_nxt_s) && (edge_cnt_r != ECNT_MAX)) begin
            edge_cnt_r <= edge_cnt_r + ECNT_ONE;
        end else begin
            edge_cnt_r <= edge_cnt_r;
        end
    end

    assign edge_cnt = edge_cnt_r;
`endif

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Randomized bench for edge_pulse_gen against a sample-window reference model,
// plus directed latency, glitch and reset-abort scenarios.
module tb_edge_pulse_gen;

    localparam int   SYNC_STAGES = 2;
    localparam int   FILTER_LEN  = 4;
    localparam int   CNT_W       = 8;
    localparam logic INIT_LEVEL  = 1'b0;
    localparam int   ECNT_W      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_in = 1'b0;
    logic level, rise_p, fall_p;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [SYNC_STAGES-1:0] sync_m;
    logic lvl_m, rise_m, fall_m;
    bit   hist[$];

`ifdef EDGE_CNT_EN
    logic              edge_cnt_clr = 1'b0;
    logic [ECNT_W-1:0] edge_cnt;
    logic [1:0]        edge_cnt_sat;
    logic              level2, rise2, fall2;
    logic              clr_v = 1'b0;
    int                ecnt_m, esat_m;
`endif

    edge_pulse_gen #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_W       (CNT_W),
        .INIT_LEVEL  (INIT_LEVEL),
        .ECNT_W      (ECNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_in         (d_in),
        .level        (level),
        .rise_p       (rise_p),
        .fall_p       (fall_p)
`ifdef EDGE_CNT_EN
        ,
        .edge_cnt_clr (edge_cnt_clr),
        .edge_cnt     (edge_cnt)
`endif
    );

`ifdef EDGE_CNT_EN
    edge_pulse_gen #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .CNT_W       (CNT_W),
        .INIT_LEVEL  (INIT_LEVEL),
        .ECNT_W      (2)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_in         (d_in),
        .level        (level2),
        .rise_p       (rise2),
        .fall_p       (fall2),
        .edge_cnt_clr (edge_cnt_clr),
        .edge_cnt     (edge_cnt_sat)
    );
`endif

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sync_m = {SYNC_STAGES{INIT_LEVEL}};
        lvl_m  = INIT_LEVEL;
        rise_m = 1'b0;
        fall_m = 1'b0;
        hist.delete();
`ifdef EDGE_CNT_EN
        ecnt_m = 0;
        esat_m = 0;
`endif
    endtask

    // One clock edge of the model: a value is accepted once the last FILTER_LEN
    // synchronized samples all differ from the current level.
    task automatic model_edge(input logic d);
        logic ds;
        bit   acc;
        ds     = sync_m[SYNC_STAGES-1];
        sync_m = {sync_m[SYNC_STAGES-2:0], d};
        hist.push_back(ds);
        while (hist.size() > FILTER_LEN) void'(hist.pop_front());
        acc = (hist.size() == FILTER_LEN);
        foreach (hist[i]) if (hist[i] == lvl_m) acc = 1'b0;
        rise_m = acc && !lvl_m;
        fall_m = acc && lvl_m;
        if (acc) begin
            lvl_m = ~lvl_m;
            hist.delete();
        end
`ifdef EDGE_CNT_EN
        if (acc && clr_v) begin
            ecnt_m = 1; esat_m = 1;
        end else if (clr_v) begin
            ecnt_m = 0; esat_m = 0;
        end else if (acc) begin
            if (ecnt_m < (1 << ECNT_W) - 1) ecnt_m++;
            if (esat_m < 3) esat_m++;
        end
`endif
    endtask

    // Called at a negedge: drive, let one posedge happen, check at the next negedge.
    task automatic cycle(input logic d);
        d_in = d;
`ifdef EDGE_CNT_EN
        edge_cnt_clr = clr_v;
`endif
        @(posedge clk);
        model_edge(d);
        @(negedge clk);
        check_eq("level", level, lvl_m);
        check_eq("rise_p", rise_p, rise_m);
        check_eq("fall_p", fall_p, fall_m);
        check_eq("rise_and_fall", rise_p & fall_p, 1'b0);
`ifdef EDGE_CNT_EN
        check_eq("edge_cnt", edge_cnt, ecnt_m[ECNT_W-1:0]);
        check_eq("edge_cnt_sat", edge_cnt_sat, esat_m[1:0]);
`endif
    endtask

    // Mid-cycle asynchronous reset spanning one posedge; released at a negedge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_level", level, INIT_LEVEL);
        check_eq("rst_rise", rise_p, 1'b0);
        check_eq("rst_fall", fall_p, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int lat;
        int pulses;
        logic v;
        int run;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("init_level", level, INIT_LEVEL);
        check_eq("init_rise", rise_p, 1'b0);
        check_eq("init_fall", fall_p, 1'b0);
        rst_n = 1'b1;

        // rise latency from a held 0->1
        lat = 0; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b1);
            if (rise_p) begin pulses++; if (lat == 0) lat = k; end
            check_eq("no_fall_on_rise", fall_p, 1'b0);
        end
        check_eq("rise_latency", lat, 6);
        check_eq("rise_count", pulses, 1);
        check_eq("level_high", level, 1'b1);

        // reset while level high forces level low without a clock
        async_reset();

        // short high burst and single-cycle glitches are rejected
        pulses = 0;
        for (int k = 0; k < 3; k++) begin cycle(1'b1); pulses += rise_p; end
        for (int k = 0; k < 8; k++) begin cycle(1'b0); pulses += rise_p; end
        for (int k = 0; k < 24; k++) begin cycle(k[0]); pulses += rise_p + fall_p; end
        for (int k = 0; k < 6; k++) begin cycle(1'b0); pulses += rise_p + fall_p; end
        check_eq("glitch_pulses", pulses, 0);
        check_eq("glitch_level", level, 1'b0);

        // fall latency from level high
        for (int k = 0; k < 10; k++) cycle(1'b1);
        lat = 0; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0);
            if (fall_p) begin pulses++; if (lat == 0) lat = k; end
        end
        check_eq("fall_latency", lat, 6);
        check_eq("fall_count", pulses, 1);
        check_eq("level_low", level, 1'b0);

        // reset mid-check aborts; rise arrives after the full latency from release
        pulses = 0;
        for (int k = 0; k < 3; k++) begin cycle(1'b1); pulses += rise_p; end
        d_in = 1'b1;
        async_reset();
        check_eq("abort_no_pulse", pulses, 0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b1);
            if (rise_p && lat == 0) lat = k;
        end
        check_eq("post_reset_rise_latency", lat, 6);

`ifdef EDGE_CNT_EN
        async_reset();
        v = 1'b0;
        for (int e = 0; e < 3; e++) begin
            v = ~v;
            for (int k = 0; k < 8; k++) cycle(v);
        end
        check_eq("edge_cnt_three", edge_cnt, 3);
        v = ~v;
        for (int k = 0; k < 5; k++) cycle(v);
        clr_v = 1'b1;
        cycle(v);
        clr_v = 1'b0;
        check_eq("clr_with_edge", edge_cnt, 1);
        for (int e = 0; e < 4; e++) begin
            v = ~v;
            for (int k = 0; k < 8; k++) cycle(v);
        end
        check_eq("sat_edge_cnt", edge_cnt_sat, 2'd3);
        clr_v = 1'b1;
        cycle(v);
        clr_v = 1'b0;
        check_eq("clr_alone", edge_cnt, 0);
`endif

        // random runs of varied length
        v = 1'b0;
        for (int r = 0; r < 400; r++) begin
            v = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 8);
            for (int k = 0; k < run; k++) begin
`ifdef EDGE_CNT_EN
                clr_v = ($urandom_range(0, 31) == 0);
`endif
                cycle(v);
            end
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
